// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter.
// Holds the grant across locked sequences and fixed-length bursts, and
// drives HMASTER/HMASTLOCK for the address/write-data muxes.
// Optional build macro: AHB_ARB_SPLIT_EN enables SPLIT masking via HSPLIT;
// without it a SPLIT response is handled exactly like RETRY.
module ahb_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]         HLOCK,
    input  logic [1:0]                       HTRANS,
    input  logic [2:0]                       HBURST,
    input  logic                             HREADY,
    input  logic [1:0]                       HRESP,
    input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
    output logic [NO_OF_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
    output logic                             HMASTLOCK
);
    localparam int                       MW      = $clog2(NO_OF_MASTERS);
    localparam logic [MW-1:0]            DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0] ONE     = NO_OF_MASTERS'(1);
    localparam logic [NO_OF_MASTERS-1:0] DEF_GNT = ONE << DEFAULT_MASTER;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RSP_OKAY  = 2'b00,
        RSP_ERROR = 2'b01,
        RSP_RETRY = 2'b10,
        RSP_SPLIT = 2'b11
    } hresp_e;

    // Remaining SEQ beats after a NONSEQ of the given burst type.
    function automatic logic [3:0] burst_len(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: burst_len = 4'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: burst_len = 4'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: burst_len = 4'd15;  // WRAP16 / INCR16
            default:        burst_len = 4'd0;   // SINGLE / INCR
        endcase
    endfunction

    logic [MW-1:0]            grant_idx;
    logic [MW-1:0]            rr_ptr;
    logic [MW-1:0]            win_idx;
    logic [MW-1:0]            cand;
    logic                     win_found;
    logic [NO_OF_MASTERS-1:0] split_mask;
    logic [NO_OF_MASTERS-1:0] split_set;
    logic [NO_OF_MASTERS-1:0] eligible;
    logic [3:0]               beat_cnt;
    logic [3:0]               beat_nxt;
    logic                     retry_edge;
    logic                     abort;
    logic                     hold;
    logic                     arb_run;

`ifdef AHB_ARB_SPLIT_EN
    // Master currently owning the bus is masked when its slave splits it.
    assign split_set  = (HREADY && HRESP == RSP_SPLIT) ? (ONE << HMASTER) : '0;
    assign retry_edge = HREADY && HRESP == RSP_RETRY;

    // Slaves release masked masters via HSPLIT; a same-cycle set wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) split_mask <= '0;
        else          split_mask <= (split_mask & ~HSPLIT) | split_set;
    end
`else
    logic unused_hsplit;
    assign unused_hsplit = ^HSPLIT;
    assign split_set     = '0;
    assign split_mask    = '0;
    assign retry_edge    = HREADY && (HRESP == RSP_RETRY || HRESP == RSP_SPLIT);
`endif

    // A just-split master is excluded from the arbitration on the same edge.
    assign eligible = HBUSREQ & ~(split_mask | split_set);

    // Round-robin search from rr_ptr+1; reverse scan so the nearest wins.
    always_comb begin
        win_idx   = DEF_IDX;
        win_found = 1'b0;
        cand      = '0;
        for (int i = NO_OF_MASTERS; i >= 1; i--) begin
            cand = MW'((int'(rr_ptr) + i) % NO_OF_MASTERS);
            if (eligible[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Burst beat counter next value; non-OKAY responses flush it at once.
    always_comb begin
        beat_nxt = beat_cnt;
        if (HRESP != RSP_OKAY) begin
            beat_nxt = 4'd0;
        end else if (HREADY) begin
            case (htrans_e'(HTRANS))
                TR_IDLE:   beat_nxt = 4'd0;
                TR_BUSY:   beat_nxt = beat_cnt;
                TR_NONSEQ: beat_nxt = burst_len(HBURST);
                TR_SEQ:    beat_nxt = (beat_cnt != 4'd0) ? beat_cnt - 4'd1 : 4'd0;
                default:   beat_nxt = 4'd0;
            endcase
        end
    end

    // Hold uses the post-edge beat count, so the grant stays put on the
    // NONSEQ that opens a burst and moves on the edge accepting its last
    // SEQ. RETRY/SPLIT responses break any lock or burst hold.
    assign abort   = HREADY && (HRESP == RSP_RETRY || HRESP == RSP_SPLIT);
    assign hold    = HLOCK[grant_idx] || (beat_nxt != 4'd0);
    assign arb_run = HREADY && (abort || !hold);

    // Grant, ownership and rotation pointer state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT    <= DEF_GNT;
            grant_idx <= DEF_IDX;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
            rr_ptr    <= DEF_IDX;
            beat_cnt  <= 4'd0;
        end else begin
            beat_cnt <= beat_nxt;
            if (HREADY) begin
                HMASTER   <= grant_idx;
                HMASTLOCK <= HLOCK[grant_idx];
                if (arb_run) begin
                    grant_idx <= win_idx;
                    HGRANT    <= ONE << win_idx;
                    // A retried master keeps its slot in the rotation.
                    if (win_found && !retry_edge) rr_ptr <= win_idx;
                end
            end
        end
    end

endmodule
